// File: rtl/float_pkg.sv
// Shared float field layout and bias helpers.
// Imported by both the int-to-float and float-to-int paths.
package float_pkg;

    localparam int DEF_MANTISSA_SIZE = 23;
    localparam int DEF_EXPONENT_SIZE = 8;

    localparam int MANTISSA_POS = 0;
    localparam int EXPONENT_POS = DEF_MANTISSA_SIZE;
    localparam int SIGN_POS     = DEF_MANTISSA_SIZE + DEF_EXPONENT_SIZE;

    function automatic int exponent_pos(input int mantissa_size);
        return MANTISSA_POS + mantissa_size;
    endfunction

    function automatic int sign_pos(input int mantissa_size,
                                    input int exponent_size);
        return MANTISSA_POS + mantissa_size + exponent_size;
    endfunction

    // Negative offsets scale the result down by powers of two.
    function automatic int bias(input int exponent_size, input int offset);
        return (1 << (exponent_size - 1)) - 1 + offset;
    endfunction

    typedef struct packed {
        logic                         sign;
        logic [DEF_EXPONENT_SIZE-1:0] exponent;
        logic [DEF_MANTISSA_SIZE-1:0] mantissa;
    } float32_t;

    function automatic float32_t make_float32(
        input logic                         sign,
        input logic [DEF_EXPONENT_SIZE-1:0] exponent,
        input logic [DEF_MANTISSA_SIZE-1:0] mantissa
    );
        float32_t f;
        f.sign     = sign;
        f.exponent = exponent;
        f.mantissa = mantissa;
        return f;
    endfunction

endpackage

// File: rtl/leading_zero_count.sv
// Combinational priority encoder: index of the highest set bit.
// zero is raised when no bit is set; index is then 0.
module leading_zero_count #(
    parameter int WIDTH = 32,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] value,
    output logic [IDX_W-1:0] index,
    output logic             zero
);

    always_comb begin
        index = '0;
        zero  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                index = IDX_W'(i);
                zero  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/int_to_float.sv
// Four-stage signed integer to packed float converter.
// Whole pipeline stalls together on output back-pressure.
module int_to_float
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE        = 23,
    parameter int EXPONENT_SIZE        = 8,
    parameter int INT_SIZE             = 32,
    parameter int EXPONENT_BIAS_OFFSET = 0,
    localparam int FLOAT_SIZE = 1 + EXPONENT_SIZE + MANTISSA_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [INT_SIZE-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FLOAT_SIZE-1:0] m_data
);

    localparam int MSB_W    = $clog2(INT_SIZE);
    localparam int BIAS     = bias(EXPONENT_SIZE, EXPONENT_BIAS_OFFSET);
    localparam int EXP_LSB  = exponent_pos(MANTISSA_SIZE);
    localparam int SIGN_BIT = sign_pos(MANTISSA_SIZE, EXPONENT_SIZE);
    localparam logic [INT_SIZE-1:0] ONE = INT_SIZE'(1);

    logic ce;

    logic                     v1_q, v1_d;
    logic                     sign1_q, sign1_d;
    logic [INT_SIZE-1:0]      mag1_q, mag1_d;

    logic                     v2_q, v2_d;
    logic                     sign2_q, sign2_d;
    logic [INT_SIZE-1:0]      mag2_q, mag2_d;
    logic [MSB_W-1:0]         msb2_q, msb2_d;
    logic                     zero2_q, zero2_d;

    logic                     v3_q, v3_d;
    logic                     sign3_q, sign3_d;
    logic                     zero3_q, zero3_d;
    logic [MANTISSA_SIZE-1:0] frac3_q, frac3_d;
    logic                     round3_q, round3_d;
    logic [EXPONENT_SIZE-1:0] exp3_q, exp3_d;

    logic                     m_valid_q, m_valid_d;
    logic [FLOAT_SIZE-1:0]    m_data_q, m_data_d;

    logic [MSB_W-1:0]         lz_idx;
    logic                     lz_zero;

    int                       msb_i;
    logic                     carry;
    logic [MANTISSA_SIZE-1:0] frac_out;
    logic [EXPONENT_SIZE-1:0] exp_out;

    assign ce      = !m_valid_q || m_ready;
    assign s_ready = ce;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    // Stage 1: sign and magnitude; the most negative input wraps to
    // exactly 2^(INT_SIZE-1) when read as unsigned.
    always_comb begin
        v1_d    = s_valid && s_ready;
        sign1_d = s_data[INT_SIZE-1];
        mag1_d  = sign1_d ? (~s_data + ONE) : s_data;
    end

    leading_zero_count #(
        .WIDTH (INT_SIZE),
        .IDX_W (MSB_W)
    ) u_lzc (
        .value (mag1_q),
        .index (lz_idx),
        .zero  (lz_zero)
    );

    always_comb begin
        v2_d    = v1_q;
        sign2_d = sign1_q;
        mag2_d  = mag1_q;
        msb2_d  = lz_idx;
        zero2_d = lz_zero;
    end

    // Stage 3: only the fraction is kept; the hidden bit is implied.
    always_comb begin
        msb_i   = int'(msb2_q);
        v3_d    = v2_q;
        sign3_d = sign2_q;
        zero3_d = zero2_q;
        exp3_d  = EXPONENT_SIZE'(msb_i + BIAS);
        if (msb_i <= MANTISSA_SIZE) begin
            frac3_d  = MANTISSA_SIZE'(mag2_q << (MANTISSA_SIZE - msb_i));
            round3_d = 1'b0;
        end else begin
            frac3_d  = MANTISSA_SIZE'(mag2_q >> (msb_i - MANTISSA_SIZE));
            round3_d = |(mag2_q & (ONE << (msb_i - MANTISSA_SIZE - 1)));
        end
    end

    // Stage 4: fraction overflow is the carry out of the hidden bit.
    always_comb begin
        {carry, frac_out} = {1'b0, frac3_q} + {{MANTISSA_SIZE{1'b0}}, round3_q};
        exp_out   = exp3_q + {{(EXPONENT_SIZE-1){1'b0}}, carry};
        m_valid_d = v3_q;
        m_data_d  = m_data_q;
        if (v3_q) begin
            if (zero3_q) begin
                m_data_d = '0;
            end else begin
                m_data_d[SIGN_BIT]                 = sign3_q;
                m_data_d[SIGN_BIT-1:EXP_LSB]       = exp_out;
                m_data_d[EXP_LSB-1:MANTISSA_POS]   = frac_out;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q      <= 1'b0;
            sign1_q   <= 1'b0;
            mag1_q    <= '0;
            v2_q      <= 1'b0;
            sign2_q   <= 1'b0;
            mag2_q    <= '0;
            msb2_q    <= '0;
            zero2_q   <= 1'b0;
            v3_q      <= 1'b0;
            sign3_q   <= 1'b0;
            zero3_q   <= 1'b0;
            frac3_q   <= '0;
            round3_q  <= 1'b0;
            exp3_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (ce) begin
            v1_q      <= v1_d;
            sign1_q   <= sign1_d;
            mag1_q    <= mag1_d;
            v2_q      <= v2_d;
            sign2_q   <= sign2_d;
            mag2_q    <= mag2_d;
            msb2_q    <= msb2_d;
            zero2_q   <= zero2_d;
            v3_q      <= v3_d;
            sign3_q   <= sign3_d;
            zero3_q   <= zero3_d;
            frac3_q   <= frac3_d;
            round3_q  <= round3_d;
            exp3_q    <= exp3_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: default instance plus a
// second instance with the exponent bias lowered by one.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [31:0] s_data, m_data;
    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data, b_m_data;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        logic [31:0] val;
        int          step;
    } exp_t;

    exp_t        sb[$];
    logic        prev_stall;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    int_to_float dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    int_to_float #(.EXPONENT_BIAS_OFFSET(-1)) dut_b (
        .clk     (clk),
        .resetn  (resetn),
        .s_valid (b_s_valid),
        .s_ready (b_s_ready),
        .s_data  (b_s_data),
        .m_valid (b_m_valid),
        .m_ready (b_m_ready),
        .m_data  (b_m_data)
    );

    function automatic logic [31:0] ref_float(input int v);
        real         r;
        logic [63:0] d;
        int          e;
        if (v == 0) return 32'h0;
        r = real'(v);
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // One clock of stimulus; expected values enter the scoreboard on
    // accept and leave it on emit, with the step count for latency.
    task automatic step(input logic sv, input logic [31:0] sd,
                        input logic [31:0] ev, input logic mr,
                        output logic acc, output logic emitted,
                        output logic [31:0] got, output logic [31:0] want,
                        output int lat, output logic live,
                        output logic rdy_ok, output logic hold_ok);
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
        rdy_ok  = (s_ready === (!m_valid || m_ready));
        hold_ok = !prev_stall || (m_valid === 1'b1 && m_data === prev_data);
        emitted = (m_valid === 1'b1) && m_ready;
        got     = m_data;
        want    = '0;
        lat     = 0;
        live    = 1'b0;
        if (emitted && sb.size() > 0) begin
            exp_t e;
            e    = sb.pop_front();
            want = e.val;
            lat  = step_no - e.step;
            live = 1'b1;
        end
        acc = s_valid && (s_ready === 1'b1);
        if (acc) sb.push_back('{ev, step_no});
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data  = m_data;
        step_no++;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;
        b_s_valid = 1'b0;
        b_s_data  = '0;
        b_m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn     = 1'b1;
        prev_stall = 1'b0;
        prev_data  = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_m_valid got=%b want=0", m_valid);
        end
        checks++;
        if (m_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_m_data got=%h want=00000000", m_data);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready got=%b want=1", s_ready);
        end
        checks++;
        if (b_m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_b_m_valid got=%b want=0", b_m_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] in_v [8] = '{32'd1, 32'hFFFFFFFF, 32'd3, 32'd0,
                                  32'd16777217, 32'h7FFFFFFF,
                                  32'h80000000, 32'd16777216};
        logic [31:0] ex_v [8] = '{32'h3F800000, 32'hBF800000,
                                  32'h40400000, 32'h00000000,
                                  32'h4B800001, 32'h4F000000,
                                  32'hCF000000, 32'h4B800000};
        logic acc, em, live, rok, hok;
        logic [31:0] got, want;
        int lat;
        int n_out = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) step(1'b1, in_v[i], ex_v[i], 1'b1,
                            acc, em, got, want, lat, live, rok, hok);
            else step(1'b0, 32'h0, 32'h0, 1'b1,
                      acc, em, got, want, lat, live, rok, hok);
            if (em) begin
                n_out++;
                checks++;
                if (!live || got !== want) begin
                    failures++;
                    $display("FAIL basic_data got=%h want=%h live=%b",
                             got, want, live);
                end
                checks++;
                if (lat != 4) begin
                    failures++;
                    $display("FAIL basic_latency got=%0d want=4", lat);
                end
            end
        end
        checks++;
        if (n_out != 8) begin
            failures++;
            $display("FAIL basic_count got=%0d want=8", n_out);
        end
    endtask

    task automatic test_bias();
        logic [31:0] in_v [2] = '{32'd2, 32'hFFFFFFFA};
        logic [31:0] ex_v [2] = '{32'h3F800000, 32'hC0400000};
        for (int i = 0; i < 2; i++) begin
            int k;
            @(negedge clk);
            b_s_valid = 1'b1;
            b_s_data  = in_v[i];
            @(negedge clk);
            b_s_valid = 1'b0;
            k = 0;
            while (b_m_valid !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            checks++;
            if (b_m_valid !== 1'b1) begin
                failures++;
                $display("FAIL bias_timeout got=%b want=1", b_m_valid);
            end else if (b_m_data !== ex_v[i]) begin
                failures++;
                $display("FAIL bias_data got=%h want=%h", b_m_data, ex_v[i]);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, em, live, rok, hok, sv, mr;
        logic [31:0] got, want;
        int lat;
        int next = 1;
        int n_out = 0;
        int guard = 0;
        while (n_out < 20 && guard < 600) begin
            sv = (next <= 20) && ($urandom_range(0, 3) != 0);
            mr = 1'($urandom_range(0, 1));
            step(sv, 32'(next), ref_float(next), mr,
                 acc, em, got, want, lat, live, rok, hok);
            if (acc) next++;
            checks++;
            if (!rok) begin
                failures++;
                $display("FAIL bp_s_ready got=%b want=%b",
                         s_ready, !m_valid || m_ready);
            end
            checks++;
            if (!hok) begin
                failures++;
                $display("FAIL bp_hold got=%h/%b want=%h/1",
                         m_data, m_valid, prev_data);
            end
            if (em) begin
                n_out++;
                checks++;
                if (!live || got !== want) begin
                    failures++;
                    $display("FAIL bp_data got=%h want=%h live=%b",
                             got, want, live);
                end
            end
            guard++;
        end
        repeat (6) begin
            step(1'b0, 32'h0, 32'h0, 1'b1,
                 acc, em, got, want, lat, live, rok, hok);
            if (em) n_out++;
        end
        checks++;
        if (n_out != 20 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_count got=%0d left=%0d want=20 left=0",
                     n_out, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic acc, em, live, rok, hok;
        logic [31:0] got, want;
        int lat;
        int next = 7;
        int n_out = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'(next), ref_float(next), 1'b0,
                 acc, em, got, want, lat, live, rok, hok);
            if (acc) next++;
        end
        checks++;
        if (m_valid !== 1'b1 || sb.size() < 3) begin
            failures++;
            $display("FAIL mid_pre_fill got=%b/%0d want=1/>=3",
                     m_valid, sb.size());
        end
        @(negedge clk);
        #2;
        resetn  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 32'h0) begin
            failures++;
            $display("FAIL mid_async_clear got=%b/%h want=0/00000000",
                     m_valid, m_data);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_s_ready got=%b want=1", s_ready);
        end
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 32'd5, 32'h40A00000, 1'b1,
             acc, em, got, want, lat, live, rok, hok);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1,
                 acc, em, got, want, lat, live, rok, hok);
            if (em) begin
                n_out++;
                checks++;
                if (!live || got !== want || lat != 4) begin
                    failures++;
                    $display("FAIL mid_after got=%h lat=%0d want=%h lat=4",
                             got, lat, want);
                end
            end
        end
        checks++;
        if (n_out != 1) begin
            failures++;
            $display("FAIL mid_count got=%0d want=1", n_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
